seg7_scan_bcd: RTL and testbench

Four-digit multiplexed seven-segment display driver for the multiplier design. It converts a 14-bit binary product to four BCD digits with a sequential double-dabble engine. It scans the digits using the divided scan clock produced by the clock divider, which sits directly upstream. The display register updates atomically, so partial conversions are never shown.

---
 rtl/seg7_scan_bcd.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_bcd.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_bcd.sv
// Four-digit multiplexed seven-segment driver with a sequential double-dabble
// binary-to-BCD converter. scan_clk is sampled as data and never clocks anything.
module seg7_scan_bcd #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic [13:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      r_state;
    logic [13:0] r_last_value;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [15:0] r_disp;
    logic        r_ovf;
    logic        r_busy;

    logic        r_s1, r_s2, r_s3;
    logic [1:0]  r_idx;

    logic [15:0] w_adj;
    logic        w_tick;
    logic [3:0]  w_digit;
    logic        w_lead_zero;
    logic        w_blank;
    logic [3:0]  w_an;
    logic [6:0]  w_seg;

    // Double-dabble add-3 correction applied before each shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM; display register and overflow load together in DONE only
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_value <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (value != r_last_value) begin
                        r_bin        <= value;
                        r_last_value <= value;
                        r_bcd        <= '0;
                        r_cnt        <= 4'd14;
                        r_busy       <= 1'b1;
                        r_state      <= StShift;
                    end
                end
                StShift: begin
                    r_bcd <= {w_adj[14:0], r_bin[13]};
                    r_bin <= {r_bin[12:0], 1'b0};
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // r_last_value is frozen outside IDLE, so it is the converted value
                    if (r_last_value > 14'd9999) begin
                        r_ovf  <= 1'b1;
                        r_disp <= '1;
                    end else begin
                        r_ovf  <= 1'b0;
                        r_disp <= r_bcd;
                    end
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // scan_clk synchronizer, edge-history flop and digit index counter
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_idx <= 2'd0;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign w_tick = r_s2 & ~r_s3;

    // Digit select, leading-zero detection and segment decode
    always_comb begin
        w_digit     = r_disp[3:0];
        w_lead_zero = 1'b0;
        w_an        = 4'b1110;
        unique case (r_idx)
            2'd0: begin
                w_digit     = r_disp[3:0];
                w_lead_zero = 1'b0;
                w_an        = 4'b1110;
            end
            2'd1: begin
                w_digit     = r_disp[7:4];
                w_lead_zero = (r_disp[15:4] == 12'd0);
                w_an        = 4'b1101;
            end
            2'd2: begin
                w_digit     = r_disp[11:8];
                w_lead_zero = (r_disp[15:8] == 8'd0);
                w_an        = 4'b1011;
            end
            2'd3: begin
                w_digit     = r_disp[15:12];
                w_lead_zero = (r_disp[15:12] == 4'd0);
                w_an        = 4'b0111;
            end
        endcase
        w_blank = BLANK_LEADING & ~r_ovf & w_lead_zero;
        if (r_ovf) begin
            w_seg = 7'b0111111;
        end else if (w_blank) begin
            w_seg = 7'b1111111;
        end else begin
            case (w_digit)
                4'd0:    w_seg = 7'b1000000;
                4'd1:    w_seg = 7'b1111001;
                4'd2:    w_seg = 7'b0100100;
                4'd3:    w_seg = 7'b0110000;
                4'd4:    w_seg = 7'b0011001;
                4'd5:    w_seg = 7'b0010010;
                4'd6:    w_seg = 7'b0000010;
                4'd7:    w_seg = 7'b1111000;
                4'd8:    w_seg = 7'b0000000;
                4'd9:    w_seg = 7'b0010000;
                default: w_seg = 7'b1111111;
            endcase
        end
    end

    // Registered anode/segment outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= w_an;
            seg <= w_seg;
        end
    end

    assign dp       = 1'b1;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Scoreboard bench for seg7_scan_bcd: one instance with leading-zero blanking,
// one without, sharing all inputs.
module tb_seg7_scan_bcd;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        scan_clk;
    logic [13:0] value;
    logic [3:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;
    logic        dp_b, dp_n, busy_b, busy_n, ovf_b, ovf_n;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg_b;
        logic [6:0] seg_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_idx  = 0;

    always #5 clk_in = ~clk_in;

    seg7_scan_bcd #(.BLANK_LEADING(1'b1)) dut_b (
        .clk_in   (clk_in),
        .reset    (reset),
        .scan_clk (scan_clk),
        .value    (value),
        .an       (an_b),
        .seg      (seg_b),
        .dp       (dp_b),
        .busy     (busy_b),
        .overflow (ovf_b)
    );

    seg7_scan_bcd #(.BLANK_LEADING(1'b0)) dut_n (
        .clk_in   (clk_in),
        .reset    (reset),
        .scan_clk (scan_clk),
        .value    (value),
        .an       (an_n),
        .seg      (seg_n),
        .dp       (dp_n),
        .busy     (busy_n),
        .overflow (ovf_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input bit blank);
        int p;
        if (v > 9999) return 7'b0111111;
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (blank && k > 0 && (v / p) == 0) return 7'b1111111;
        return seg_code((v / p) % 10);
    endfunction

    function automatic logic [3:0] an_code(input int k);
        logic [3:0] a;
        a = 4'b1111;
        a[k] = 1'b0;
        return a;
    endfunction

    function automatic exp_t mk_exp(input int v, input int k);
        exp_t e;
        e.an    = an_code(k);
        e.seg_b = exp_seg(v, k, 1'b1);
        e.seg_n = exp_seg(v, k, 1'b0);
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_an"}, {28'd0, an_b}, 32'hF);
        check_eq({tag, "_seg"}, {25'd0, seg_b}, 32'h7F);
        check_eq({tag, "_dp"}, {31'd0, dp_b}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy_b}, 32'd0);
        check_eq({tag, "_ovf"}, {31'd0, ovf_b}, 32'd0);
    endtask

    // Drive a value and check busy width and final overflow
    task automatic conv(input int v, input bit ovf_exp);
        int busy_cnt;
        busy_cnt = 0;
        value = 14'(v);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in);
            #1;
            if (busy_b) busy_cnt++;
            if (c == 0) check_eq("busy_rise", {31'd0, busy_b}, 32'd1);
        end
        check_eq("busy_len", busy_cnt, 15);
        check_eq("ovf", {31'd0, ovf_b}, {31'd0, ovf_exp});
        check_eq("ovf_n", {31'd0, ovf_n}, {31'd0, ovf_exp});
    endtask

    task automatic scan_pulse();
        scan_clk = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        exp_idx = (exp_idx + 1) % 4;
    endtask

    task automatic scan_release();
        scan_clk = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    // Scan all four digits, comparing against queued expectations
    task automatic scan_all(input int v);
        exp_t e;
        for (int i = 1; i <= 4; i++) exp_q.push_back(mk_exp(v, (exp_idx + i) % 4));
        for (int i = 0; i < 4; i++) begin
            scan_pulse();
            e = exp_q.pop_front();
            check_eq("scan_an", {28'd0, an_b}, {28'd0, e.an});
            check_eq("scan_seg_b", {25'd0, seg_b}, {25'd0, e.seg_b});
            check_eq("scan_seg_n", {25'd0, seg_n}, {25'd0, e.seg_n});
            check_eq("scan_dp", {31'd0, dp_b}, 32'd1);
            scan_release();
        end
    endtask

    initial begin
        exp_t e;
        int   bad;
        logic [6:0] s_old, s_a, s_b;
        reset    = 1'b1;
        scan_clk = 1'b0;
        value    = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        exp_idx = 0;
        exp_q.push_back(mk_exp(0, 0));
        e = exp_q.pop_front();
        check_eq("idle_an", {28'd0, an_b}, {28'd0, e.an});
        check_eq("idle_seg", {25'd0, seg_b}, {25'd0, e.seg_b});
        check_eq("idle_busy", {31'd0, busy_b}, 32'd0);
        scan_all(0);
        check_eq("idle_busy2", {31'd0, busy_b}, 32'd0);

        conv(1234, 1'b0);
        scan_all(1234);
        conv(10000, 1'b1);
        scan_all(10000);
        conv(42, 1'b0);
        scan_all(42);

        // 9999 then 5 mid-conversion: only 42, 9999, 5 may appear
        exp_q.push_back(mk_exp(42, exp_idx));
        exp_q.push_back(mk_exp(9999, exp_idx));
        exp_q.push_back(mk_exp(9999, exp_idx));
        exp_q.push_back(mk_exp(5, exp_idx));
        s_old = exp_seg(42, exp_idx, 1'b1);
        s_a   = exp_seg(9999, exp_idx, 1'b1);
        s_b   = exp_seg(5, exp_idx, 1'b1);
        bad   = 0;
        value = 14'd9999;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_in);
            #1;
            if (c == 4) value = 14'd5;
            if (seg_b !== s_old && seg_b !== s_a && seg_b !== s_b) bad++;
            if (c == 15 || c == 16 || c == 31 || c == 32) begin
                e = exp_q.pop_front();
                check_eq($sformatf("chg_seg_c%0d", c), {25'd0, seg_b}, {25'd0, e.seg_b});
            end
            if (c == 16) check_eq("chg_busy2", {31'd0, busy_b}, 32'd1);
        end
        check_eq("chg_no_other", bad, 0);
        scan_all(5);

        // Reset in the middle of a conversion of 777
        value = 14'd777;
        repeat (8) @(posedge clk_in);
        #1;
        check_eq("mid_busy", {31'd0, busy_b}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk_in);
        #1;
        reset   = 1'b0;
        exp_idx = 0;
        conv(777, 1'b0);
        scan_all(777);

        // No-blank instance shows leading zeros
        conv(7, 1'b0);
        scan_all(7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
